aes_key_sched: RTL

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_key_sched.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched.sv
// Word-serial AES-128/192/256 key expansion into 2**SLOT_W schedule slots with a combinational round-key read port.
// Defining AES_KEY_ZEROIZE_EN adds a zeroize input that wipes every slot and forces the block idle.
module aes_key_sched #(
    parameter int SLOT_W = 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                                   zeroize,
`endif
    input  logic [255:0]                           key,
    input  logic [1:0]                             keylen,
    input  logic [((SLOT_W > 0) ? SLOT_W : 1)-1:0] wr_slot,
    input  logic                                   init,
    output logic                                   ready,
    output logic                                   error,
    input  logic [((SLOT_W > 0) ? SLOT_W : 1)-1:0] rd_slot,
    input  logic [3:0]                             round,
    output logic [127:0]                           round_key,
    output logic [(1 << SLOT_W)-1:0]               slot_valid,
    output logic [31:0]                            sboxw,
    input  logic [31:0]                            new_sboxw
);

    localparam int SW        = (SLOT_W > 0) ? SLOT_W : 1;
    localparam int KEY_SLOTS = 1 << SLOT_W;
    localparam int NW_MAX    = 60;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'b00:   return 4'd4;
            2'b10:   return 4'd6;
            2'b01:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input logic [1:0] kl);
        case (kl)
            2'b00:   return 6'd44;
            2'b10:   return 6'd52;
            2'b01:   return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b00:   return 4'd10;
            2'b10:   return 4'd12;
            2'b01:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [KEY_SLOTS-1:0]  slot_valid_q, slot_valid_d;
    logic [1:0]            klen_q, klen_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [255:0]          key_q, key_d;
    logic [5:0]            i_q, i_d;
    logic [2:0]            m_q, m_d;
    logic [7:0]            rcon_q, rcon_d;
    logic [31:0]           win_q [8];
    logic [31:0]           win_d [8];
    logic [31:0]           mem_q [KEY_SLOTS][NW_MAX];
    logic [1:0]            mem_klen_q [KEY_SLOTS];

    logic                  zero_s;
    logic                  accept_s;
    logic                  legal_s;
    logic [SW-1:0]         wr_idx_s;
    logic [SW-1:0]         rd_idx_s;
    logic [3:0]            nk_s;
    logic [2:0]            nk_m1_s;
    logic [5:0]            nw_s;
    logic [31:0]           kw_s [8];
    logic [31:0]           t_s;
    logic [31:0]           w_new_s;
    logic                  rcon_step_s;
    logic                  mem_we_s;
    logic                  klen_we_s;
    logic                  mem_clr_s;
    logic [5:0]            rd_base_s;
    logic [3:0]            nk_tmp_s;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_s = zeroize;
`else
    assign zero_s = 1'b0;
`endif

    assign wr_idx_s = (SLOT_W == 0) ? '0 : wr_slot;
    assign rd_idx_s = (SLOT_W == 0) ? '0 : rd_slot;
    assign legal_s  = (keylen != 2'b11);
    assign accept_s = ready_q && init && !zero_s;
    assign nk_s     = nk_of(klen_q);
    assign nk_tmp_s = nk_s - 4'd1;
    assign nk_m1_s  = nk_tmp_s[2:0];
    assign nw_s     = nw_of(klen_q);

    // Next schedule word: key words first, then w[i-Nk] ^ t from the sliding window.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            kw_s[j] = key_q[(7 - j) * 32 +: 32];
        end
        rcon_step_s = 1'b0;
        t_s         = win_q[0];
        if (i_q < {2'b00, nk_s}) begin
            w_new_s = kw_s[i_q[2:0]];
        end else begin
            if (m_q == 3'd0) begin
                t_s         = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h000000};
                rcon_step_s = 1'b1;
            end else if ((nk_s == 4'd8) && (m_q == 3'd4)) begin
                t_s = new_sboxw;
            end else begin
                t_s = win_q[0];
            end
            w_new_s = win_q[nk_m1_s] ^ t_s;
        end
    end

    // Control next-state: zeroize dominates, then the IDLE/GEN/DONE sequence.
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        error_d      = error_q;
        slot_valid_d = slot_valid_q;
        klen_d       = klen_q;
        slot_d       = slot_q;
        key_d        = key_q;
        i_d          = i_q;
        m_d          = m_q;
        rcon_d       = rcon_q;
        win_d        = win_q;
        mem_we_s     = 1'b0;
        klen_we_s    = 1'b0;
        mem_clr_s    = 1'b0;
        if (zero_s) begin
            state_d      = IDLE;
            ready_d      = 1'b1;
            error_d      = 1'b0;
            slot_valid_d = '0;
            key_d        = 256'h0;
            i_d          = 6'd0;
            m_d          = 3'd0;
            rcon_d       = 8'h00;
            mem_clr_s    = 1'b1;
            for (int j = 0; j < 8; j++) begin
                win_d[j] = 32'h0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s && legal_s) begin
                        state_d                = GEN;
                        ready_d                = 1'b0;
                        error_d                = 1'b0;
                        klen_d                 = keylen;
                        slot_d                 = wr_idx_s;
                        key_d                  = key;
                        i_d                    = 6'd0;
                        m_d                    = 3'd0;
                        rcon_d                 = 8'h01;
                        slot_valid_d[wr_idx_s] = 1'b0;
                        klen_we_s              = 1'b1;
                    end else if (accept_s) begin
                        error_d = 1'b1;
                    end else if (!ready_q) begin
                        // One idle cycle after DONE publishes the finished slot together with ready.
                        ready_d              = 1'b1;
                        slot_valid_d[slot_q] = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                GEN: begin
                    mem_we_s = 1'b1;
                    win_d[0] = w_new_s;
                    for (int j = 1; j < 8; j++) begin
                        win_d[j] = win_q[j-1];
                    end
                    i_d = i_q + 6'd1;
                    m_d = (m_q == nk_m1_s) ? 3'd0 : (m_q + 3'd1);
                    if (rcon_step_s) begin
                        rcon_d = xtime(rcon_q);
                    end else begin
                        rcon_d = rcon_q;
                    end
                    if (i_q == (nw_s - 6'd1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = GEN;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            error_q      <= 1'b0;
            slot_valid_q <= '0;
            klen_q       <= 2'b00;
            slot_q       <= '0;
            key_q        <= 256'h0;
            i_q          <= 6'd0;
            m_q          <= 3'd0;
            rcon_q       <= 8'h00;
            for (int j = 0; j < 8; j++) begin
                win_q[j] <= 32'h0;
            end
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            slot_valid_q <= slot_valid_d;
            klen_q       <= klen_d;
            slot_q       <= slot_d;
            key_q        <= key_d;
            i_q          <= i_d;
            m_q          <= m_d;
            rcon_q       <= rcon_d;
            win_q        <= win_d;
        end
    end

    // Schedule storage and per-slot key length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < KEY_SLOTS; s++) begin
                mem_klen_q[s] <= 2'b00;
                for (int k = 0; k < NW_MAX; k++) begin
                    mem_q[s][k] <= 32'h0;
                end
            end
        end else if (mem_clr_s) begin
            for (int s = 0; s < KEY_SLOTS; s++) begin
                mem_klen_q[s] <= 2'b00;
                for (int k = 0; k < NW_MAX; k++) begin
                    mem_q[s][k] <= 32'h0;
                end
            end
        end else begin
            if (mem_we_s) begin
                mem_q[slot_q][i_q] <= w_new_s;
            end
            if (klen_we_s) begin
                mem_klen_q[wr_idx_s] <= keylen;
            end
        end
    end

    // Round-key read; invalid slots and rounds past Nr read as zero.
    always_comb begin
        rd_base_s = {round, 2'b00};
        if (slot_valid_q[rd_idx_s] && (round <= nr_of(mem_klen_q[rd_idx_s]))) begin
            round_key = {mem_q[rd_idx_s][rd_base_s],
                         mem_q[rd_idx_s][rd_base_s + 6'd1],
                         mem_q[rd_idx_s][rd_base_s + 6'd2],
                         mem_q[rd_idx_s][rd_base_s + 6'd3]};
        end else begin
            round_key = 128'h0;
        end
    end

    assign ready      = ready_q;
    assign error      = error_q;
    assign slot_valid = slot_valid_q;
    assign sboxw      = win_q[0];

endmodule
